regfile_multiport: RTL and testbench

Parametrised successor to the 16×64 register bank. It provides NREGS registers of DW bits, one write port with half-word enables and an in-place half swap, and NRD independently registered read ports with per-port constant select. It adds write-to-read bypass and a sequenced bulk-clear engine. It sits between the datapath controller and the ALU operand registers.

---
 rtl/regfile_pkg.sv | 36 +++
 rtl/regfile_rdport.sv | 52 +++++
 rtl/regfile_multiport.sv | 141 ++++++++++++++
 tb/tb_regfile_multiport.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared encodings, clear-FSM state type and the post-write word function for the
// multiport register bank.
package regfile_pkg;

  localparam logic [1:0] EN_BOTH = 2'b00;
  localparam logic [1:0] EN_HIGH = 2'b01;
  localparam logic [1:0] EN_LOW  = 2'b10;
  localparam logic [1:0] EN_SWAP = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Widest register the shared write function can handle; callers zero-extend.
  localparam int MAX_DW = 512;
  typedef logic [MAX_DW-1:0] word_t;

  // Post-write value of a register of width 2*hw, used by the write and bypass paths.
  function automatic word_t post_write(input word_t old_w, input word_t in_w,
                                       input logic [1:0] mode, input int unsigned hw);
    word_t lo_mask;
    word_t hi_mask;
    word_t res;
    lo_mask = (word_t'(1) << hw) - word_t'(1);
    hi_mask = lo_mask << hw;
    case (mode)
      EN_BOTH: res = in_w & (hi_mask | lo_mask);
      EN_HIGH: res = (in_w & hi_mask) | (old_w & lo_mask);
      EN_LOW:  res = (old_w & hi_mask) | (in_w & lo_mask);
      default: res = ((old_w & lo_mask) << hw) | ((old_w & hi_mask) >> hw);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: constant select, out-of-range zero and write-first bypass.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DW = 64,
  parameter int NREGS = 16,
  parameter int AW = 4,
  parameter logic [DW-1:0] CONST_VAL = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          cnst,
  input  logic [AW-1:0] sel,
  input  logic [DW-1:0] regs [NREGS],
  input  logic          byp_en,
  input  logic [AW-1:0] byp_idx,
  input  logic [DW-1:0] byp_data,
  output logic [DW-1:0] out
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [DW-1:0] out_d;
  logic [DW-1:0] out_q;

  always_comb begin
    out_d = out_q;
    if (en) begin
      if (cnst) begin
        out_d = CONST_VAL;
      end else if ({1'b0, sel} >= NREGS_W) begin
        out_d = '0;
      end else if (byp_en && (byp_idx == sel)) begin
        out_d = byp_data;
      end else begin
        out_d = regs[sel];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/regfile_multiport.sv
// NREGS x DW register bank: one half-word-enabled write port, NRD registered read
// ports with write-first bypass, and a sequenced bulk-clear engine.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DW = 64,
  parameter int NREGS = 16,
  parameter int NRD = 2,
  parameter logic [DW-1:0] CONST_VAL = '0,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              regwen,
  input  logic [DW-1:0]     inA,
  input  logic [AW-1:0]     selwreg,
  input  logic [1:0]        endreg,
  input  logic [NRD*AW-1:0] selout,
  input  logic [NRD-1:0]    cnst,
  input  logic [NRD-1:0]    enrreg,
  output logic [NRD*DW-1:0] out,
  input  logic              clr,
  output logic              busy,
  output logic              wdrop,
  output clr_state_e        dbg_state
);

  localparam int HW = DW / 2;
  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wdrop_q, wdrop_d;

  logic          in_range, wr_en, clr_en;
  logic [AW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  word_t         wr_full;
  logic          wr_unused;
  logic          byp_en;
  logic [AW-1:0] byp_idx;
  logic [DW-1:0] byp_data;

  assign busy = (state_q == ST_CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_en = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Out-of-range indices are steered to 0 only to keep the array access in bounds.
  always_comb begin
    in_range = ({1'b0, selwreg} < NREGS_W);
    wr_en    = regwen && !busy && in_range;
    wr_idx   = in_range ? selwreg : '0;
    wr_full  = post_write(word_t'(regs_q[wr_idx]), word_t'(inA), endreg, HW);
    wr_data  = wr_full[DW-1:0];
    wdrop_d  = regwen && busy;
  end

  assign wr_unused = ^wr_full[MAX_DW-1:DW];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_idx] = wr_data;
    end
    if (clr_en) begin
      regs_d[cnt_q] = '0;
    end
  end

  // The write and the clear never coincide, so one bypass channel serves both.
  always_comb begin
    byp_en   = wr_en || clr_en;
    byp_idx  = clr_en ? cnt_q : wr_idx;
    byp_data = clr_en ? '0 : wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wdrop_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdrop_q <= wdrop_d;
    end
  end

  assign wdrop     = wdrop_q;
  assign dbg_state = state_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_rdport #(
      .DW(DW),
      .NREGS(NREGS),
      .AW(AW),
      .CONST_VAL(CONST_VAL)
    ) u_rd (
      .clock(clock),
      .reset(reset),
      .en(enrreg[p]),
      .cnst(cnst[p]),
      .sel(selout[p*AW +: AW]),
      .regs(regs_q),
      .byp_en(byp_en),
      .byp_idx(byp_idx),
      .byp_data(byp_data),
      .out(out[p*DW +: DW])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: scoreboard-checked 16x64/2-port instance plus
// a 12-register/3-port instance for range handling.
module tb_regfile_multiport;
  import regfile_pkg::*;

  localparam logic [63:0] CV = 64'hC0DE_0000_0000_BEEF;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Instance A: 16 registers, 2 read ports, non-zero constant.
  logic          regwen;
  logic [63:0]   inA;
  logic [3:0]    selwreg;
  logic [1:0]    endreg;
  logic [7:0]    selout;
  logic [1:0]    cnst, enrreg;
  logic [127:0]  out;
  logic          clr, busy, wdrop;
  clr_state_e    dbg_state;

  regfile_multiport #(.DW(64), .NREGS(16), .NRD(2), .CONST_VAL(CV)) dut (
    .clock(clock), .reset(reset), .regwen(regwen), .inA(inA), .selwreg(selwreg),
    .endreg(endreg), .selout(selout), .cnst(cnst), .enrreg(enrreg), .out(out),
    .clr(clr), .busy(busy), .wdrop(wdrop), .dbg_state(dbg_state)
  );

  // Instance B: 12 registers, 3 read ports, default constant.
  logic          b_regwen;
  logic [63:0]   b_inA;
  logic [3:0]    b_selwreg;
  logic [1:0]    b_endreg;
  logic [11:0]   b_selout;
  logic [2:0]    b_cnst, b_enrreg;
  logic [191:0]  b_out;
  logic          b_clr, b_busy, b_wdrop;
  clr_state_e    b_dbg;

  regfile_multiport #(.DW(64), .NREGS(12), .NRD(3)) dut12 (
    .clock(clock), .reset(reset), .regwen(b_regwen), .inA(b_inA), .selwreg(b_selwreg),
    .endreg(b_endreg), .selout(b_selout), .cnst(b_cnst), .enrreg(b_enrreg), .out(b_out),
    .clr(b_clr), .busy(b_busy), .wdrop(b_wdrop), .dbg_state(b_dbg)
  );

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  // Reference model of instance A
  logic [63:0] m_regs [16];
  logic [63:0] m_out0, m_out1;
  logic        m_busy, m_wdrop;
  logic [3:0]  m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] mw(input logic [63:0] old_w, input logic [63:0] in_w,
                                     input logic [1:0] mode);
    case (mode)
      2'b00:   return in_w;
      2'b01:   return {in_w[63:32], old_w[31:0]};
      2'b10:   return {old_w[63:32], in_w[31:0]};
      default: return {old_w[31:0], old_w[63:32]};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_out0 = '0; m_out1 = '0; m_busy = 1'b0; m_wdrop = 1'b0; m_cnt = '0;
  endtask

  // One clock of instance A: drive, predict into the queue, clock, then pop and compare.
  task automatic cyc(input string tag, input logic wen, input logic [3:0] widx,
                     input logic [63:0] wd, input logic [1:0] mode, input logic [1:0] ren,
                     input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] cst,
                     input logic c);
    logic [63:0] nregs [16];
    regwen = wen; selwreg = widx; inA = wd; endreg = mode;
    enrreg = ren; selout = {s1, s0}; cnst = cst; clr = c;
    nregs = m_regs;
    if (wen && !m_busy) nregs[widx] = mw(m_regs[widx], wd, mode);
    if (m_busy) nregs[m_cnt] = '0;
    if (ren[0]) m_out0 = cst[0] ? CV : nregs[s0];
    if (ren[1]) m_out1 = cst[1] ? CV : nregs[s1];
    m_wdrop = wen && m_busy;
    if (m_busy) begin
      if (m_cnt == 4'd15) m_busy = 1'b0;
      else m_cnt = m_cnt + 4'd1;
    end else if (c) begin
      m_busy = 1'b1;
      m_cnt = '0;
    end
    m_regs = nregs;
    exp_q.push_back(m_out0);
    exp_q.push_back(m_out1);
    exp_q.push_back({63'b0, m_busy});
    exp_q.push_back({63'b0, m_wdrop});
    @(posedge clock);
    @(negedge clock);
    check({tag, ".out0"}, out[63:0], exp_q.pop_front());
    check({tag, ".out1"}, out[127:64], exp_q.pop_front());
    check({tag, ".busy"}, {63'b0, busy}, exp_q.pop_front());
    check({tag, ".wdrop"}, {63'b0, wdrop}, exp_q.pop_front());
  endtask

  task automatic b_tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    regwen = 0; inA = '0; selwreg = '0; endreg = '0; selout = '0; cnst = '0; enrreg = '0; clr = 0;
    b_regwen = 0; b_inA = '0; b_selwreg = '0; b_endreg = '0; b_selout = '0;
    b_cnst = '0; b_enrreg = '0; b_clr = 0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check("rst.out", out[63:0] | out[127:64], 64'h0);
    check("rst.busy", {63'b0, busy}, 64'h0);
    check("rst.state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0;

    // Full and partial writes, read one cycle later and through the bypass
    cyc("w3", 1, 4'd3, 64'h1111_2222_3333_4444, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 0);
    cyc("r3", 0, 4'd0, 64'h0, 2'b00, 2'b01, 4'd3, 4'd0, 2'b00, 0);
    cyc("wh", 1, 4'd3, 64'hAAAA_AAAA_BBBB_BBBB, 2'b01, 2'b00, 4'd0, 4'd0, 2'b00, 0);
    cyc("rh", 0, 4'd0, 64'h0, 2'b00, 2'b10, 4'd0, 4'd3, 2'b00, 0);
    cyc("wl", 1, 4'd3, 64'hCCCC_CCCC_DDDD_DDDD, 2'b10, 2'b01, 4'd3, 4'd0, 2'b00, 0);
    cyc("ws", 1, 4'd3, 64'h0, 2'b11, 2'b11, 4'd3, 4'd3, 2'b10, 0);
    cyc("byp5", 1, 4'd5, 64'h5, 2'b00, 2'b10, 4'd0, 4'd5, 2'b00, 0);
    cyc("cst1", 0, 4'd0, 64'h0, 2'b00, 2'b10, 4'd0, 4'd5, 2'b10, 0);
    cyc("hold", 1, 4'd5, 64'h77, 2'b00, 2'b00, 4'd5, 4'd5, 2'b00, 0);
    cyc("r5", 0, 4'd0, 64'h0, 2'b00, 2'b11, 4'd5, 4'd3, 2'b00, 0);

    // Fill, then bulk clear with a concurrent write, a dropped write and a stray clr
    for (int i = 0; i < 16; i++)
      cyc("fill", 1, 4'(i), {$urandom(), $urandom()}, 2'b00, 2'b01, 4'(i), 4'd0, 2'b00, 0);
    cyc("clr", 1, 4'd2, 64'h2222, 2'b00, 2'b10, 4'd0, 4'd2, 2'b00, 1);
    for (int i = 0; i < 16; i++)
      cyc("clrseq", i == 4, 4'd7, 64'hDEAD, 2'b00, 2'b11, 4'(i), 4'd15, 2'b00, i == 2);
    for (int i = 0; i < 16; i += 2)
      cyc("post", 0, 4'd0, 64'h0, 2'b00, 2'b11, 4'(i), 4'(i + 1), 2'b00, 0);

    // Asynchronous reset in the middle of a clear sequence and mid-cycle
    cyc("f12", 1, 4'd12, 64'h1212_0000_0000_1212, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 0);
    cyc("f13", 1, 4'd13, 64'h1313_0000_0000_1313, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 0);
    cyc("clr2", 0, 4'd0, 64'h0, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 1);
    for (int i = 0; i < 3; i++)
      cyc("midclr", 0, 4'd0, 64'h0, 2'b00, 2'b11, 4'd12, 4'd13, 2'b00, 0);
    #2 reset = 1'b1;
    #1;
    check("arst.out0", out[63:0], 64'h0);
    check("arst.out1", out[127:64], 64'h0);
    check("arst.busy", {63'b0, busy}, 64'h0);
    check("arst.state", 64'(dbg_state), 64'(ST_IDLE));
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    cyc("arst.r", 0, 4'd0, 64'h0, 2'b00, 2'b11, 4'd12, 4'd13, 2'b00, 0);
    cyc("arst.r2", 0, 4'd0, 64'h0, 2'b00, 2'b11, 4'd3, 4'd15, 2'b00, 0);

    // Instance B: out-of-range write ignored, out-of-range read gives 0, three ports
    b_regwen = 1; b_selwreg = 4'd1; b_inA = 64'h1111; b_tick();
    b_selwreg = 4'd13; b_inA = 64'hBAD0; b_tick();
    check("b.wdrop", {63'b0, b_wdrop}, 64'h0);
    b_selwreg = 4'd2; b_inA = 64'h2222; b_tick();
    b_selwreg = 4'd11; b_inA = 64'hBBBB; b_tick();
    b_regwen = 0; b_enrreg = 3'b111; b_selout = {4'd11, 4'd14, 4'd1}; b_tick();
    check("b.p0", b_out[63:0], 64'h1111);
    check("b.p1", b_out[127:64], 64'h0);
    check("b.p2", b_out[191:128], 64'hBBBB);
    b_selout = {4'd0, 4'd13, 4'd2}; b_tick();
    check("b.p0b", b_out[63:0], 64'h2222);
    check("b.p1b", b_out[127:64], 64'h0);
    check("b.p2b", b_out[191:128], 64'h0);
    b_selout = {4'd2, 4'd1, 4'd11}; b_cnst = 3'b010; b_tick();
    check("b.p0c", b_out[63:0], 64'hBBBB);
    check("b.p1c", b_out[127:64], 64'h0);
    check("b.p2c", b_out[191:128], 64'h2222);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
